// File: rtl/qea_z_expect_reader.sv
// QEA readout stage: after a QEA run, sweep the state RAM row by row,
// square every amplitude and accumulate the per-qubit Pauli-Z expectation
// <Z_i> together with the total norm.
//
// Handshake: i_start is a single-cycle request. It is accepted only in IDLE,
// and never on the first clock after reset release. o_state_ena marks every
// cycle whose o_state_addra is a real read, and that row's data arrives on
// i_state_dout RD_LATENCY cycles later. o_done is a one-cycle pulse that marks
// o_z_expect / o_norm as valid. Those outputs hold until the next accepted
// start, which clears them.
module qea_z_expect_reader #(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH*2,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int NUM_FRAC_BIT     = 30,
  parameter int NUM_Z_OUT        = 8,
  parameter int ACC_WIDTH        = 40,
  parameter int RD_LATENCY       = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  output logic                               o_state_ena,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [NUM_Z_OUT*ACC_WIDTH-1:0]     o_z_expect,
  output logic [ACC_WIDTH-1:0]               o_norm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IDX_WIDTH     = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int ROW_CNT_WIDTH = STATE_ADDR_WIDTH + 1;
  localparam logic [MAX_QBIT_WIDTH-1:0] N_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] N_MAX = MAX_QBIT_WIDTH'(IDX_WIDTH);

  // FSM state is kept as a named signal so that checkers can bind to it.
  state_t state;
  state_t state_next;

  logic                        armed;
  logic                        start_accept;
  logic [STATE_ADDR_WIDTH-1:0] addr;
  logic [STATE_ADDR_WIDTH-1:0] last_row;
  logic [NUM_Z_OUT-1:0]        z_mask;

  logic [MAX_QBIT_WIDTH-1:0]   n_clamped;
  logic [ROW_CNT_WIDTH-1:0]    rows_new;
  logic [NUM_Z_OUT-1:0]        z_mask_new;

  logic [RD_LATENCY-1:0]       v_pipe;
  logic [STATE_ADDR_WIDTH-1:0] row_pipe [RD_LATENCY];

  logic signed [ACC_WIDTH-1:0] prob [PE_NUM];
  logic                        s1_valid;
  logic [STATE_ADDR_WIDTH-1:0] s1_row;
  logic signed [ACC_WIDTH-1:0] s1_prob [PE_NUM];

  logic [NUM_Z_OUT-1:0]        k_idx;
  logic signed [ACC_WIDTH-1:0] z_delta [NUM_Z_OUT];
  logic signed [ACC_WIDTH-1:0] norm_delta;

  logic signed [ACC_WIDTH-1:0] z_acc [NUM_Z_OUT];
  logic signed [ACC_WIDTH-1:0] norm_acc;

  // Clamp the requested qubit count, then derive the row count and the set of live qubits.
  always_comb begin
    n_clamped = i_qbit_num;
    if (i_qbit_num < N_MIN) begin
      n_clamped = N_MIN;
    end else if (i_qbit_num > N_MAX) begin
      n_clamped = N_MAX;
    end
    rows_new   = ROW_CNT_WIDTH'(1) << (n_clamped - N_MIN);
    z_mask_new = '0;
    for (int i = 0; i < NUM_Z_OUT; i++) begin
      z_mask_new[i] = (MAX_QBIT_WIDTH'(i) < n_clamped);
    end
  end

  // Next-state logic and decode of the FSM outputs.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    o_state_ena  = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && armed) begin
          start_accept = 1'b1;
          state_next   = READ;
        end
      end
      READ: begin
        o_state_ena = 1'b1;
        o_busy      = 1'b1;
        if (addr == last_row) state_next = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        // With the read pipeline empty, the last row is in S1 and is folded into the accumulators on this edge.
        if (v_pipe == '0) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register. 'armed' blocks a start on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  // Sweep configuration and the row address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      last_row <= '0;
      z_mask   <= '0;
    end else if (start_accept) begin
      addr     <= '0;
      last_row <= STATE_ADDR_WIDTH'(rows_new - ROW_CNT_WIDTH'(1));
      z_mask   <= z_mask_new;
    end else if (state == READ) begin
      addr <= (addr == last_row) ? '0 : addr + STATE_ADDR_WIDTH'(1);
    end
  end

  assign o_state_addra = addr;

  // Delay the read-valid flag and row number so they line up with i_state_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      for (int j = 0; j < RD_LATENCY; j++) row_pipe[j] <= '0;
    end else begin
      v_pipe[0]   <= o_state_ena;
      row_pipe[0] <= addr;
      for (int j = 1; j < RD_LATENCY; j++) begin
        v_pipe[j]   <= v_pipe[j-1];
        row_pipe[j] <= row_pipe[j-1];
      end
    end
  end

  // Squared magnitude per PE. The 2*DATA_WIDTH+1 intermediate holds re^2+im^2 exactly.
  for (genvar p = 0; p < PE_NUM; p++) begin : g_pe
    logic signed [DATA_WIDTH-1:0]   re;
    logic signed [DATA_WIDTH-1:0]   im;
    logic signed [2*DATA_WIDTH:0]   re_x;
    logic signed [2*DATA_WIDTH:0]   im_x;
    logic signed [2*DATA_WIDTH:0]   sq;
    assign re      = i_state_dout[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: DATA_WIDTH];
    assign im      = i_state_dout[(PE_NUM-p)*STATE_DATA_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
    assign re_x    = (2*DATA_WIDTH+1)'(re);
    assign im_x    = (2*DATA_WIDTH+1)'(im);
    assign sq      = re_x * re_x + im_x * im_x;
    assign prob[p] = ACC_WIDTH'(sq >>> NUM_FRAC_BIT);
  end

  // Stage S1: register the per-PE probabilities together with their row number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_row   <= '0;
      for (int p = 0; p < PE_NUM; p++) s1_prob[p] <= '0;
    end else begin
      s1_valid <= v_pipe[RD_LATENCY-1];
      s1_row   <= row_pipe[RD_LATENCY-1];
      for (int p = 0; p < PE_NUM; p++) s1_prob[p] <= prob[p];
    end
  end

  // Row contribution: bit i of k = row*PE_NUM + p sets the sign of each term for qubit i.
  always_comb begin
    norm_delta = '0;
    k_idx      = '0;
    for (int i = 0; i < NUM_Z_OUT; i++) z_delta[i] = '0;
    for (int p = 0; p < PE_NUM; p++) begin
      norm_delta = norm_delta + s1_prob[p];
      k_idx      = NUM_Z_OUT'({s1_row, PE_NUM_WIDTH'(p)});
      for (int i = 0; i < NUM_Z_OUT; i++) begin
        if (k_idx[i]) z_delta[i] = z_delta[i] - s1_prob[p];
        else          z_delta[i] = z_delta[i] + s1_prob[p];
      end
    end
  end

  // Stage S2: the accumulators. Cleared on an accepted start; qubits beyond n stay at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      norm_acc <= '0;
      for (int i = 0; i < NUM_Z_OUT; i++) z_acc[i] <= '0;
    end else if (start_accept) begin
      norm_acc <= '0;
      for (int i = 0; i < NUM_Z_OUT; i++) z_acc[i] <= '0;
    end else if (s1_valid) begin
      norm_acc <= norm_acc + norm_delta;
      for (int i = 0; i < NUM_Z_OUT; i++) begin
        if (z_mask[i]) z_acc[i] <= z_acc[i] + z_delta[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_Z_OUT; i++) begin : g_zout
    assign o_z_expect[(i+1)*ACC_WIDTH-1 : i*ACC_WIDTH] = z_acc[i];
  end
  assign o_norm = norm_acc;

endmodule

// File: tb/tb_qea_z_expect_reader.sv
// Testbench for qea_z_expect_reader. Two instances are used: one with read
// latency 1 and one with read latency 3. Each has its own behavioural state
// RAM, and both read the shared amplitude arrays. Expected results come from
// a fixed vector table and from a reference model that sums over amplitude
// indices.
module tb_qea_z_expect_reader;

  localparam int DW  = 32;
  localparam int PE  = 4;
  localparam int SDW = 64;
  localparam int AW  = 16;
  localparam int QW  = 6;
  localparam int NZ  = 8;
  localparam int ACC = 40;
  localparam int NAMP = 512;
  localparam logic [ACC-1:0] ONE     = 40'h0040000000;
  localparam logic [ACC-1:0] NEG_ONE = 40'hFFC0000000;
  localparam logic [DW-1:0]  AMP_ONE = 32'h40000000;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start1, start3;
  logic [QW-1:0] qbit;
  logic ena1, ena3, busy1, busy3, done1, done3;
  logic [AW-1:0] addr1, addr3;
  logic [PE*SDW-1:0] dout1 = '0;
  logic [PE*SDW-1:0] dout3 = '0;
  logic [PE*SDW-1:0] pipe_a = '0;
  logic [PE*SDW-1:0] pipe_b = '0;
  logic [NZ*ACC-1:0] z1, z3;
  logic [ACC-1:0] norm1, norm3;

  logic [DW-1:0] amp_re [NAMP];
  logic [DW-1:0] amp_im [NAMP];

  logic [ACC-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qea_z_expect_reader #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_qbit_num(qbit),
    .o_state_ena(ena1), .o_state_addra(addr1), .i_state_dout(dout1),
    .o_busy(busy1), .o_done(done1), .o_z_expect(z1), .o_norm(norm1)
  );

  qea_z_expect_reader #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .i_qbit_num(qbit),
    .o_state_ena(ena3), .o_state_addra(addr3), .i_state_dout(dout3),
    .o_busy(busy3), .o_done(done3), .o_z_expect(z3), .o_norm(norm3)
  );

  // ---------------- state RAM models ----------------
  function automatic logic [PE*SDW-1:0] row_data(input logic [AW-1:0] a);
    logic [PE*SDW-1:0] r;
    int k;
    r = '0;
    for (int p = 0; p < PE; p++) begin
      k = int'(a[6:0]) * PE + p;
      r[(PE-p)*SDW-1 -: SDW] = {amp_re[k], amp_im[k]};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (ena1) dout1 <= row_data(addr1);
  end

  always @(posedge clk) begin
    if (ena3) pipe_a <= row_data(addr3);
    pipe_b <= pipe_a;
    dout3  <= pipe_b;
  end

  // ---------------- driver helpers ----------------
  function automatic logic sel_done(input int lat);
    return (lat == 1) ? done1 : done3;
  endfunction
  function automatic logic sel_busy(input int lat);
    return (lat == 1) ? busy1 : busy3;
  endfunction
  function automatic logic sel_ena(input int lat);
    return (lat == 1) ? ena1 : ena3;
  endfunction
  function automatic logic [AW-1:0] sel_addr(input int lat);
    return (lat == 1) ? addr1 : addr3;
  endfunction
  function automatic logic [NZ*ACC-1:0] sel_z(input int lat);
    return (lat == 1) ? z1 : z3;
  endfunction
  function automatic logic [ACC-1:0] sel_norm(input int lat);
    return (lat == 1) ? norm1 : norm3;
  endfunction

  task automatic set_start(input int lat, input logic v);
    if (lat == 1) start1 = v;
    else          start3 = v;
  endtask

  task automatic clear_amps();
    for (int k = 0; k < NAMP; k++) begin
      amp_re[k] = '0;
      amp_im[k] = '0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model. Each amplitude index k contributes |a_k|^2 to the norm.
  // It adds +|a_k|^2 to <Z_i> when bit i of k is 0 and -|a_k|^2 when bit i is 1, for qubits i < n.
  task automatic model_push(input int n);
    longint z [NZ];
    longint nm;
    longint p;
    logic signed [64:0] r, m, sq;
    nm = 0;
    for (int i = 0; i < NZ; i++) z[i] = 0;
    for (int k = 0; k < (1 << n); k++) begin
      r  = $signed(amp_re[k]);
      m  = $signed(amp_im[k]);
      sq = r * r + m * m;
      p  = longint'(sq >>> 30);
      nm += p;
      for (int i = 0; i < NZ; i++) begin
        if (i < n) z[i] += (((k >> i) & 1) != 0) ? -p : p;
      end
    end
    for (int i = 0; i < NZ; i++) exp_q.push_back(ACC'(z[i]));
    exp_q.push_back(ACC'(nm));
  endtask

  // One complete sweep: pulse start, then follow the address stream, the o_done timing and the results.
  // With poke set, extra starts are issued during READ and in the DONE cycle; both must be ignored.
  task automatic run_sweep(input int lat, input int n, input int exp_done, input bit poke);
    logic [ACC-1:0] ev [9];
    logic [NZ*ACC-1:0] zv;
    int rows, cyc, nrows, done_at;
    bit addr_ok, busy_ok;
    for (int i = 0; i < 9; i++) ev[i] = exp_q.pop_front();
    rows = 1 << (n - 2);
    qbit = QW'(n);
    set_start(lat, 1'b1);
    @(posedge clk); #1;
    set_start(lat, 1'b0);
    cyc = 1; nrows = 0; done_at = -1; addr_ok = 1'b1; busy_ok = 1'b1;
    while (cyc < rows + lat + 40) begin
      if (sel_done(lat)) begin
        done_at = cyc;
        break;
      end
      if (!sel_busy(lat)) busy_ok = 1'b0;
      if (sel_ena(lat)) begin
        if (sel_addr(lat) != AW'(nrows) || cyc != 1 + nrows) addr_ok = 1'b0;
        nrows++;
      end
      set_start(lat, poke && cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    set_start(lat, 1'b0);
    chk($sformatf("done_cycle L%0d n%0d", lat, n), 64'(done_at), 64'(exp_done));
    chk("rows_read", 64'(nrows), 64'(rows));
    chk("addr_sequence", 64'(addr_ok), 64'd1);
    chk("busy_during_sweep", 64'(busy_ok), 64'd1);
    chk("busy_at_done", 64'(sel_busy(lat)), 64'd0);
    zv = sel_z(lat);
    for (int i = 0; i < NZ; i++) chk($sformatf("z%0d", i), 64'(zv[i*ACC +: ACC]), 64'(ev[i]));
    chk("norm", 64'(sel_norm(lat)), 64'(ev[8]));
    if (poke) set_start(lat, 1'b1);
    @(posedge clk); #1;
    set_start(lat, 1'b0);
    chk("done_one_cycle", 64'(sel_done(lat)), 64'd0);
    chk("idle_after_done", 64'(sel_busy(lat)), 64'd0);
    zv = sel_z(lat);
    for (int i = 0; i < NZ; i++) chk($sformatf("z%0d_hold", i), 64'(zv[i*ACC +: ACC]), 64'(ev[i]));
    chk("norm_hold", 64'(sel_norm(lat)), 64'(ev[8]));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            lat;
    int            n;
    bit            uniform;
    int            idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            pos;      // qubits expected at +1.0
    int            neg;      // qubits expected at -1.0
    logic [ACC-1:0] norm;
    int            done_cyc;
    bit            poke;
  } vec_t;

  localparam int NT = 8;
  vec_t tbl [NT];

  int rn, rlat;
  bit saw;

  initial begin
    tbl[0] = '{1, 4, 1'b0,   0, AMP_ONE,       32'h0,         'hF,  'h0,  ONE,   7, 1'b0};
    tbl[1] = '{1, 4, 1'b0,  15, AMP_ONE,       32'h0,         'h0,  'hF,  ONE,   7, 1'b0};
    tbl[2] = '{1, 4, 1'b1,   0, 32'h10000000,  32'h0,         'h0,  'h0,  ONE,   7, 1'b0};
    tbl[3] = '{1, 4, 1'b0,   5, 32'h0,         32'hC0000000,  'hA,  'h5,  ONE,   7, 1'b1};
    tbl[4] = '{1, 2, 1'b0,   2, AMP_ONE,       32'h0,         'h1,  'h2,  ONE,   4, 1'b0};
    tbl[5] = '{3, 6, 1'b0,   0, AMP_ONE,       32'h0,         'h3F, 'h0,  ONE,  21, 1'b1};
    tbl[6] = '{1, 7, 1'b0,   0, AMP_ONE,       32'h0,         'h7F, 'h0,  ONE,  35, 1'b0};
    tbl[7] = '{3, 9, 1'b0, 128, AMP_ONE,       32'h0,         'h7F, 'h80, ONE, 133, 1'b0};

    // ---- reset ----
    rst_n = 1'b1; start1 = 1'b0; start3 = 1'b0; qbit = '0;
    clear_amps();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ena", 64'(ena1), 64'd0);
    chk("reset_busy", 64'(busy1), 64'd0);
    chk("reset_done", 64'(done1), 64'd0);
    chk("reset_addr", 64'(addr1), 64'd0);
    chk("reset_norm", 64'(norm1), 64'd0);
    for (int i = 0; i < NZ; i++) chk($sformatf("reset_z%0d", i), 64'(z1[i*ACC +: ACC]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven sweeps ----
    for (int c = 0; c < NT; c++) begin
      clear_amps();
      if (tbl[c].uniform) begin
        for (int k = 0; k < (1 << tbl[c].n); k++) begin
          amp_re[k] = tbl[c].re;
          amp_im[k] = tbl[c].im;
        end
      end else begin
        amp_re[tbl[c].idx] = tbl[c].re;
        amp_im[tbl[c].idx] = tbl[c].im;
      end
      for (int i = 0; i < NZ; i++) begin
        if (((tbl[c].pos >> i) & 1) != 0)      exp_q.push_back(ONE);
        else if (((tbl[c].neg >> i) & 1) != 0) exp_q.push_back(NEG_ONE);
        else                                   exp_q.push_back('0);
      end
      exp_q.push_back(tbl[c].norm);
      run_sweep(tbl[c].lat, tbl[c].n, tbl[c].done_cyc, tbl[c].poke);
    end

    // ---- reset mid-sweep aborts; start at reset release is ignored ----
    clear_amps();
    amp_re[0] = AMP_ONE;
    qbit = QW'(4);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("abort_busy_before", 64'(busy1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ena", 64'(ena1), 64'd0);
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_addr", 64'(addr1), 64'd0);
    chk("abort_norm", 64'(norm1), 64'd0);
    saw = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done1) saw = 1'b1;
    end
    rst_n  = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("start_at_release_ignored", 64'(busy1), 64'd0);
    repeat (8) begin
      @(posedge clk); #1;
      if (done1 || busy1) saw = 1'b1;
    end
    chk("no_done_after_abort", 64'(saw), 64'd0);
    for (int i = 0; i < NZ; i++) exp_q.push_back((i < 4) ? ONE : '0);
    exp_q.push_back(ONE);
    run_sweep(1, 4, 7, 1'b0);

    // ---- randomized sweeps against the reference model ----
    for (int t = 0; t < 8; t++) begin
      rn   = $urandom_range(2, 6);
      rlat = ($urandom_range(0, 1) == 1) ? 3 : 1;
      clear_amps();
      for (int k = 0; k < (1 << rn); k++) begin
        amp_re[k] = $urandom;
        amp_im[k] = $urandom;
      end
      model_push(rn);
      run_sweep(rlat, rn, (1 << (rn - 2)) + rlat + 2, bit'(t & 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qea_z_expect_reader.md
Name: qea_z_expect_reader

Overview:
- Downstream readout stage of QEA. After QEA asserts o_complete, this block sweeps the QEA state RAM through its external state port.
- Per amplitude it computes the probability |a|^2 and accumulates the Pauli-Z expectation <Z_i> for each qubit, plus the total norm.
- Its outputs are the quanvolutional feature values handed to the classical layer. It replaces the bench-driven readout loop.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM.
- PE_NUM, 4, amplitudes per state RAM row.
- DATA_WIDTH, 32, width of one real or imag component (signed, fixed point).
- STATE_DATA_WIDTH, DATA_WIDTH*2, one complex amplitude: {re, im}, re in upper half.
- STATE_ADDR_WIDTH, 16, state RAM row address width.
- MAX_QBIT_WIDTH, 6, width of the qubit-count input.
- NUM_FRAC_BIT, 30, fractional bits of amplitudes and of all outputs.
- NUM_Z_OUT, 8, number of <Z_i> outputs (qubits 0..NUM_Z_OUT-1).
- ACC_WIDTH, 40, signed accumulator and output width.
- RD_LATENCY, 1, state RAM read latency in cycles (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; begins a sweep (tie to QEA o_complete rising edge)
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count n, sampled on accepted start
- o_state_ena  out  1  read enable to QEA i_state_ena (replicated per PE at top level); write enable is held 0 at top level
- o_state_addra  out  STATE_ADDR_WIDTH  row address to QEA i_state_addra
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  QEA o_state_dout; PE p occupies bits [(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH]
- o_busy  out  1  high from the cycle after start accept until o_done
- o_done  out  1  one-cycle pulse; results valid from this cycle
- o_z_expect  out  NUM_Z_OUT*ACC_WIDTH  <Z_i> in Q(ACC_WIDTH-30).30; qubit i in bits [(i+1)*ACC_WIDTH-1 : i*ACC_WIDTH]
- o_norm  out  ACC_WIDTH  sum of all |a|^2, same format (1.0 = 2^30)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulators and valid pipeline cleared. Reset mid-sweep aborts immediately; no o_done is produced.
- Amplitude index k = row*PE_NUM + p. Bit i of k selects the sign for qubit i: 0 gives +|a|^2, 1 gives -|a|^2.
- ROWS = 2^(n-PE_NUM_WIDTH). n below PE_NUM_WIDTH is clamped to PE_NUM_WIDTH. n above STATE_ADDR_WIDTH+PE_NUM_WIDTH is clamped to that value.
- Qubits i >= n, or i >= NUM_Z_OUT, are not computed; their outputs are 0.
- FSM states:
  - IDLE: on i_start, latch ROWS, clear accumulators, go to READ.
  - READ: o_state_ena=1; addresses 0..ROWS-1 are issued on consecutive cycles; after the last address go to DRAIN.
  - DRAIN: o_state_ena=0; wait until the valid pipeline is empty and the final accumulate has completed.
  - DONE: o_done=1 for one cycle, o_busy=0; then go to IDLE.
- Pipeline:
  - A valid bit and the row number are delayed RD_LATENCY cycles to align with i_state_dout.
  - Stage S1 (registered): prob_p = (re*re + im*im) >>> NUM_FRAC_BIT, using a 2*DATA_WIDTH+1-bit intermediate; arithmetic shift, truncation.
  - Stage S2 (registered): accumulate; each accumulator adds the signed sum over the PE_NUM probabilities of the row. Sign per PE uses the full index k.
- Timing: start accepted in cycle 0. Row r address is in cycle 1+r. o_done is in cycle ROWS+RD_LATENCY+2.
- Accumulators are sign-extended to ACC_WIDTH; no saturation. ACC_WIDTH>=NUM_FRAC_BIT+3 is guaranteed for normalized states.
- Outputs hold their values after o_done until the next accepted i_start; they are cleared at that start.
- i_start while o_busy or in DONE is ignored. i_start in the same cycle as reset release is ignored.

Test Plan:
- n=4, row0 PE0 = 0x40000000_00000000, all else 0; pulse start -> o_state_ena high for 4 cycles, addr 0..3; o_done at cycle 7; o_z_expect[0..3] = 0x0040000000 each, [4..7] = 0, o_norm = 0x0040000000.
- n=4, only index 15 (row3 PE3) = 0x40000000_00000000 -> z[0..3] = -2^30 (0xFFC0000000), norm = 2^30.
- n=4, all 16 amplitudes re = 0x10000000, im = 0 -> each prob 2^26; z[0..3] = 0, norm = 2^30.
- n=4, index 5 (row1 PE1) = 0x00000000_C0000000 (im = -1.0) -> z0 = -2^30, z1 = +2^30, z2 = -2^30, z3 = +2^30.
- Second i_start during READ ignored; rst_n low at cycle 3 -> outputs 0, no o_done; fresh start after release completes the sweep normally.
- RD_LATENCY=3, n=6 (16 rows), |0> state -> o_done at cycle 21; z[0..5] = 2^30, z[6..7] = 0.
